// File: rtl/axi4_uart_slave.sv
// AXI4 slave for the 16-byte UART window: TXDATA writes feed a byte FIFO that an
// 8N1 transmitter drains onto uart_tx; STATUS reports transmitter and FIFO state.
module axi4_uart_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
  parameter int          CLK_DIV    = 1250,
  parameter int          FIFO_DEPTH = 8,
  parameter int          ID_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_AWVALID,
  output logic            s_AWREADY,
  input  logic [31:0]     s_AWADDR,
  input  logic [ID_W-1:0] s_AWID,
  input  logic [7:0]      s_AWLEN,
  input  logic            s_WVALID,
  output logic            s_WREADY,
  input  logic [31:0]     s_WDATA,
  input  logic [3:0]      s_WSTRB,
  input  logic            s_WLAST,
  output logic            s_BVALID,
  input  logic            s_BREADY,
  output logic [1:0]      s_BRESP,
  output logic [ID_W-1:0] s_BID,
  input  logic            s_ARVALID,
  output logic            s_ARREADY,
  input  logic [31:0]     s_ARADDR,
  input  logic [ID_W-1:0] s_ARID,
  input  logic [7:0]      s_ARLEN,
  output logic            s_RVALID,
  input  logic            s_RREADY,
  output logic [31:0]     s_RDATA,
  output logic [1:0]      s_RRESP,
  output logic [ID_W-1:0] s_RID,
  output logic            s_RLAST,
  output logic            uart_tx
);

  localparam int          PTR_W       = $clog2(FIFO_DEPTH);
  localparam int          CNT_W       = PTR_W + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;
  typedef enum logic       {TX_IDLE, TX_SHIFT}      txstate_t;

  wstate_t          r_wState, w_wNext;
  rstate_t          r_rState, w_rNext;
  txstate_t         r_txState, w_txNext;
  logic             r_wInWin, r_rInWin;
  logic [3:0]       r_wOff, r_rOff;
  logic [ID_W-1:0]  r_awId, r_arId;
  logic [7:0]       r_beatsLeft;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic [9:0]       r_shift;
  logic [3:0]       r_bitIdx;
  logic [15:0]      r_baud;
  logic             w_full, w_empty, w_push, w_pop, w_txBusy, w_wTxTarget, w_wBlock;
  logic             w_bitEnd;
  logic [31:0]      w_regData;
  logic             w_unused;

  assign w_unused    = ^{s_AWLEN, s_WDATA[31:8], s_WSTRB[3:1]};
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_wTxTarget = r_wInWin && (r_wOff == 4'h0);
  assign w_wBlock    = w_wTxTarget && w_full;
  assign w_push      = s_WVALID && s_WREADY && w_wTxTarget && s_WSTRB[0];
  assign w_txBusy    = (r_txState == TX_SHIFT);
  assign w_bitEnd    = (r_baud == 16'd0);
  assign s_BID       = r_awId;
  assign s_RID       = r_arId;
  assign uart_tx     = (r_txState == TX_SHIFT) ? r_shift[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wState <= W_IDLE;
      r_wInWin <= 1'b0;
      r_wOff   <= 4'h0;
      r_awId   <= '0;
    end else begin
      r_wState <= w_wNext;
      if (s_AWVALID && s_AWREADY) begin
        r_wInWin <= (s_AWADDR[31:4] == BASE_ADDR[31:4]);
        r_wOff   <= s_AWADDR[3:0];
        r_awId   <= s_AWID;
      end
    end
  end

  // A TXDATA burst holds WREADY low while the FIFO is full so no byte is dropped.
  always_comb begin
    w_wNext   = r_wState;
    s_AWREADY = 1'b0;
    s_WREADY  = 1'b0;
    s_BVALID  = 1'b0;
    s_BRESP   = 2'b00;
    case (r_wState)
      W_IDLE: begin
        s_AWREADY = 1'b1;
        if (s_AWVALID) w_wNext = W_DATA;
      end
      W_DATA: begin
        s_WREADY = !w_wBlock;
        if (s_WVALID && !w_wBlock && s_WLAST) w_wNext = W_RESP;
      end
      W_RESP: begin
        s_BVALID = 1'b1;
        s_BRESP  = r_wInWin ? 2'b00 : 2'b11;
        if (s_BREADY) w_wNext = W_IDLE;
      end
      default: w_wNext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rState    <= R_IDLE;
      r_rInWin    <= 1'b0;
      r_rOff      <= 4'h0;
      r_arId      <= '0;
      r_beatsLeft <= 8'd0;
    end else begin
      r_rState <= w_rNext;
      if (s_ARVALID && s_ARREADY) begin
        r_rInWin    <= (s_ARADDR[31:4] == BASE_ADDR[31:4]);
        r_rOff      <= s_ARADDR[3:0];
        r_arId      <= s_ARID;
        r_beatsLeft <= s_ARLEN;
      end else if (s_RVALID && s_RREADY && !s_RLAST) begin
        r_beatsLeft <= r_beatsLeft - 1'b1;
      end
    end
  end

  always_comb begin
    w_regData = 32'd0;
    if (r_rInWin && r_rOff == 4'h4)
      w_regData = {23'd0, 5'(r_count), 1'b0, w_empty, w_full, w_txBusy};
  end

  always_comb begin
    w_rNext   = r_rState;
    s_ARREADY = 1'b0;
    s_RVALID  = 1'b0;
    s_RLAST   = 1'b0;
    s_RDATA   = 32'd0;
    s_RRESP   = 2'b00;
    case (r_rState)
      R_IDLE: begin
        s_ARREADY = 1'b1;
        if (s_ARVALID) w_rNext = R_DATA;
      end
      R_DATA: begin
        s_RVALID = 1'b1;
        s_RLAST  = (r_beatsLeft == 8'd0);
        s_RRESP  = r_rInWin ? 2'b00 : 2'b11;
        s_RDATA  = w_regData;
        if (s_RREADY && r_beatsLeft == 8'd0) w_rNext = R_IDLE;
      end
      default: w_rNext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= s_WDATA[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Popping at the end of the stop bit lets the next start bit follow with no idle gap.
  always_comb begin
    w_txNext = r_txState;
    w_pop    = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop    = 1'b1;
          w_txNext = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (w_bitEnd && r_bitIdx == 4'd9) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_txNext = TX_IDLE;
        end
      end
      default: w_txNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txState <= TX_IDLE;
      r_shift   <= '1;
      r_bitIdx  <= 4'd0;
      r_baud    <= 16'd0;
    end else begin
      r_txState <= w_txNext;
      if (w_pop) begin
        r_shift  <= {1'b1, r_mem[r_rdPtr], 1'b0};
        r_bitIdx <= 4'd0;
        r_baud   <= BAUD_RELOAD;
      end else if (r_txState == TX_SHIFT) begin
        if (w_bitEnd) begin
          r_shift  <= {1'b1, r_shift[9:1]};
          r_bitIdx <= r_bitIdx + 1'b1;
          r_baud   <= BAUD_RELOAD;
        end else begin
          r_baud <= r_baud - 1'b1;
        end
      end
    end
  end

endmodule
